// File: rtl/dither_gen_pkg.sv
// rtl/dither_gen_pkg.sv - shared widths, mode encodings, per-LFSR default seeds and tap masks
package dither_gen_pkg;

  localparam int T_BITS  = 14;
  localparam int F_BITS  = 12;
  localparam int MAX_SRC = 6;
  localparam int SEED_W  = 25;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RPDF = 2'b01,
    MODE_SUM  = 2'b10,
    MODE_HP   = 2'b11
  } mode_e;

  // LFSR k is 20+k bits wide; seeds and masks are right-aligned in SEED_W bits
  function automatic logic [SEED_W-1:0] default_seed(input int k);
    case (k)
      0:       return 25'h00A_BCDE;
      1:       return 25'h008_FA82;
      2:       return 25'h013_CBAF;
      3:       return 25'h03B_113F;
      4:       return 25'h051_2345;
      default: return 25'h012_882B;
    endcase
  endfunction

  function automatic logic [SEED_W-1:0] tap_mask(input int k);
    case (k)
      0:       return 25'h009_0000;
      1:       return 25'h014_0000;
      2:       return 25'h030_0000;
      3:       return 25'h042_0000;
      4:       return 25'h0E1_0000;
      default: return 25'h120_0000;
    endcase
  endfunction

endpackage

// File: rtl/dither_gen_lfsr.sv
// rtl/dither_gen_lfsr.sv - one XNOR LFSR with step, seed load and all-ones recovery
module lfsr_xnor #(
  parameter int          W     = 20,
  parameter int          SRC_W = 12,
  parameter logic [24:0] TAPS  = 25'h009_0000,
  parameter logic [24:0] SEED  = 25'h00A_BCDE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [W-1:0]     seed,
  output logic [SRC_W-1:0] src,
  output logic             lockup
);

  logic [W-1:0] state;
  logic [W-1:0] state_nxt;
  logic         fb;

  // All-ones is the XNOR dead state: never load it, and escape it if ever found
  always_comb begin
    fb        = ~^(state & TAPS[W-1:0]);
    state_nxt = state;
    lockup    = 1'b0;
    if (&state) begin
      state_nxt = SEED[W-1:0];
      lockup    = 1'b1;
    end else if (load) begin
      if (&seed) begin
        state_nxt = SEED[W-1:0];
        lockup    = 1'b1;
      end else begin
        state_nxt = seed;
      end
    end else if (step) begin
      state_nxt = {state[W-2:0], fb};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SEED[W-1:0];
    else        state <= state_nxt;
  end

  assign src = state_nxt[SRC_W-1:0];

endmodule

// File: rtl/dither_gen.sv
// rtl/dither_gen.sv - multi-LFSR dither: adder tree, two-stage pipeline, high-pass, shift and saturate
module dither_gen
  import dither_gen_pkg::*;
#(
  parameter int OUT_W = T_BITS,
  parameter int SRC_W = F_BITS,
  parameter int N_SRC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_i,
  input  logic [1:0]       mode_i,
  input  logic [2:0]       shift_i,
  input  logic             seed_we_i,
  input  logic [2:0]       seed_sel_i,
  input  logic [24:0]      seed_i,
  output logic [OUT_W-1:0] dith_o,
  output logic             valid_o,
  output logic             lockup_o
);

  localparam int SUM_W = SRC_W + $clog2(N_SRC) + 1;
  localparam int DW    = SUM_W + 1;
  localparam int CW    = (DW > OUT_W) ? DW : OUT_W;
  localparam logic signed [CW-1:0] SAT_MAX = CW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [SRC_W-1:0] src [N_SRC];
  logic [N_SRC-1:0]        lock_vec;

  for (genvar k = 0; k < N_SRC; k++) begin : g_lfsr
    lfsr_xnor #(
      .W     (20 + k),
      .SRC_W (SRC_W),
      .TAPS  (tap_mask(k)),
      .SEED  (default_seed(k))
    ) u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .step   (sample_i),
      .load   (seed_we_i && (seed_sel_i == 3'(k))),
      .seed   (seed_i[20+k-1:0]),
      .src    (src[k]),
      .lockup (lock_vec[k])
    );
  end

  logic signed [SUM_W-1:0] sum_all, sum_c, sum_r, prev_sum;
  logic                    s1_valid;

  always_comb begin
    sum_all = '0;
    for (int k = 0; k < N_SRC; k++) sum_all = sum_all + SUM_W'(src[k]);
    case (mode_i)
      MODE_OFF:  sum_c = '0;
      MODE_RPDF: sum_c = SUM_W'(src[0]);
      default:   sum_c = sum_all;
    endcase
  end

  logic signed [DW-1:0] cur_x, prev_x, d, d_sh;
  logic signed [CW-1:0] d_w, sat;

  // One extra bit keeps sum_r - prev_sum exact before shifting and clamping
  always_comb begin
    cur_x  = DW'(sum_r);
    prev_x = (mode_i == MODE_HP) ? DW'(prev_sum) : '0;
    d      = cur_x - prev_x;
    d_sh   = d >>> shift_i;
    d_w    = CW'(d_sh);
    if (d_w > SAT_MAX)      sat = SAT_MAX;
    else if (d_w < SAT_MIN) sat = SAT_MIN;
    else                    sat = d_w;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_r    <= '0;
      s1_valid <= 1'b0;
      prev_sum <= '0;
      dith_o   <= '0;
      valid_o  <= 1'b0;
      lockup_o <= 1'b0;
    end else begin
      s1_valid <= sample_i;
      if (sample_i) sum_r <= sum_c;
      valid_o  <= s1_valid;
      lockup_o <= |lock_vec;
      if (s1_valid) begin
        dith_o   <= sat[OUT_W-1:0];
        prev_sum <= sum_r;
      end
    end
  end

endmodule

// File: tb/tb_dither_gen.sv
// tb/tb_dither_gen.sv - self-checking bench for dither_gen with a word-level behavioural model
module tb_dither_gen;

  localparam int OUT_W = 12;
  localparam int SRC_W = 12;
  localparam int N_SRC = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             sample_i = 1'b0;
  logic [1:0]       mode_i = 2'b00;
  logic [2:0]       shift_i = 3'd0;
  logic             seed_we_i = 1'b0;
  logic [2:0]       seed_sel_i = 3'd0;
  logic [24:0]      seed_i = '0;
  logic [OUT_W-1:0] dith_o;
  logic             valid_o;
  logic             lockup_o;

  dither_gen #(.OUT_W(OUT_W), .SRC_W(SRC_W), .N_SRC(N_SRC)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .sample_i   (sample_i),
    .mode_i     (mode_i),
    .shift_i    (shift_i),
    .seed_we_i  (seed_we_i),
    .seed_sel_i (seed_sel_i),
    .seed_i     (seed_i),
    .dith_o     (dith_o),
    .valid_o    (valid_o),
    .lockup_o   (lockup_o)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: LFSR states as plain integers, each word computed from the arithmetic rules
  int unsigned def_seed [6] = '{32'h0A_BCDE, 32'h08_FA82, 32'h13_CBAF,
                                32'h3B_113F, 32'h51_2345, 32'h12_882B};
  int unsigned m_st [6];
  int          m_p1_sum, m_prev;
  bit          m_p1_v;
  logic [11:0] exp_dith;
  bit          exp_valid, exp_lock;

  function automatic int unsigned m_step(int k, int unsigned s);
    int unsigned x;
    case (k)
      0:       x = (s >> 19) ^ (s >> 16);
      1:       x = (s >> 20) ^ (s >> 18);
      2:       x = (s >> 21) ^ (s >> 20);
      3:       x = (s >> 22) ^ (s >> 17);
      4:       x = (s >> 23) ^ (s >> 22) ^ (s >> 21) ^ (s >> 16);
      default: x = (s >> 24) ^ (s >> 21);
    endcase
    return ((s << 1) | (~x & 1)) & ((32'd1 << (20 + k)) - 1);
  endfunction

  function automatic int sx12(int unsigned v);
    int unsigned t = v & 32'hFFF;
    return (t >= 2048) ? int'(t) - 4096 : int'(t);
  endfunction

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      for (int k = 0; k < N_SRC; k++) m_st[k] = def_seed[k];
      m_p1_sum = 0; m_prev = 0; m_p1_v = 0;
      exp_dith = '0; exp_valid = 0; exp_lock = 0;
    end else begin
      int d;
      int sum;
      int unsigned mask, sv;
      exp_lock = 0;
      if (m_p1_v) begin
        d = (mode_i == 2'b11) ? m_p1_sum - m_prev : m_p1_sum;
        d = d >>> shift_i;
        if (d > 2047) d = 2047;
        if (d < -2048) d = -2048;
        exp_dith  = d[11:0];
        exp_valid = 1;
        m_prev    = m_p1_sum;
      end else begin
        exp_valid = 0;
      end
      for (int k = 0; k < N_SRC; k++) begin
        mask = (32'd1 << (20 + k)) - 1;
        if (m_st[k] == mask) begin
          m_st[k] = def_seed[k]; exp_lock = 1;
        end else if (seed_we_i && seed_sel_i == 3'(k)) begin
          sv = seed_i & mask;
          if (sv == mask) begin m_st[k] = def_seed[k]; exp_lock = 1; end
          else m_st[k] = sv;
        end else if (sample_i) begin
          m_st[k] = m_step(k, m_st[k]);
        end
      end
      m_p1_v = sample_i;
      if (sample_i) begin
        sum = 0;
        for (int k = 0; k < N_SRC; k++) sum += sx12(m_st[k]);
        case (mode_i)
          2'b00:   m_p1_sum = 0;
          2'b01:   m_p1_sum = sx12(m_st[0]);
          default: m_p1_sum = sum;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (valid_o) vcount++;
    if (reset && cmp_en) begin
      chk("cyc_dith", int'(dith_o), int'(exp_dith));
      chk("cyc_valid", int'(valid_o), int'(exp_valid));
      chk("cyc_lockup", int'(lockup_o), int'(exp_lock));
    end
  end

  task automatic tick;
    @(negedge clock);
    #2;
  endtask

  task automatic one_sample(input logic [1:0] m, input logic [2:0] s);
    mode_i = m; shift_i = s; sample_i = 1'b1;
    tick;
    sample_i = 1'b0;
    tick;
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_dith", int'(dith_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_lockup", int'(lockup_o), 0);
    reset = 1'b1;
    cmp_en = 1'b1;
    tick;

    // First RPDF word after reset: LFSR0 steps to 20'h579BC
    one_sample(2'b01, 3'd0);
    chk("t1_valid", int'(valid_o), 1);
    chk("t1_dith", int'(dith_o), 12'h9BC);
    chk("t1_model", int'(exp_dith), 12'h9BC);
    tick;
    chk("t1_single", int'(valid_o), 0);

    mode_i = 2'b00; vcount = 0; sample_i = 1'b1;
    repeat (100) tick;
    sample_i = 1'b0;
    repeat (3) tick;
    chk("t2_count", vcount, 100);
    chk("t2_dith", int'(dith_o), 0);

    // All sources +2047 after one step from 0x3FF
    for (int k = 0; k < N_SRC; k++) begin
      seed_we_i = 1'b1; seed_sel_i = 3'(k); seed_i = 25'h3FF;
      tick;
    end
    seed_we_i = 1'b0;
    one_sample(2'b10, 3'd0);
    chk("t5_sat_pos", int'(dith_o), 12'h7FF);
    tick;
    one_sample(2'b11, 3'd3);
    chk("t3_hp_first", int'(dith_o), 12'hA00);
    one_sample(2'b11, 3'd3);
    chk("t3_hp_zero", int'(dith_o), 0);
    one_sample(2'b11, 3'd0);
    chk("t3_hp_hold", int'(dith_o), 0);

    for (int k = 0; k < N_SRC; k++) begin
      seed_we_i = 1'b1; seed_sel_i = 3'(k);
      seed_i = (k == 2) ? 25'h1FF_FFFF : 25'h3FF;
      tick;
      if (k == 2) chk("t4_lock_pulse", int'(lockup_o), 1);
    end
    seed_we_i = 1'b0;
    tick;
    chk("t4_lock_clear", int'(lockup_o), 0);
    one_sample(2'b10, 3'd3);
    chk("t4_reload_word", int'(dith_o), 12'h5EB);

    seed_we_i = 1'b1; seed_sel_i = 3'd2; seed_i = 25'h1FF_FFFF; sample_i = 1'b1;
    tick;
    seed_we_i = 1'b0; sample_i = 1'b0;
    chk("t4_lock_step", int'(lockup_o), 1);
    tick;
    seed_we_i = 1'b1; seed_sel_i = 3'd7;
    tick;
    seed_we_i = 1'b0;
    chk("t4_sel_ignored", int'(lockup_o), 0);
    tick;

    // Reset while a word is in stage 1
    mode_i = 2'b01; shift_i = 3'd0; sample_i = 1'b1;
    tick;
    sample_i = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_rst_dith", int'(dith_o), 0);
    chk("t6_rst_valid", int'(valid_o), 0);
    tick;
    tick;
    reset = 1'b1;
    vcount = 0;
    repeat (5) tick;
    chk("t6_no_valid", vcount, 0);
    one_sample(2'b01, 3'd0);
    chk("t6_restart", int'(dith_o), 12'h9BC);

    for (int i = 0; i < 3000; i++) begin
      sample_i = ($urandom % 4) != 0;
      if ($urandom % 64 == 0) begin
        mode_i  = 2'($urandom);
        shift_i = 3'($urandom);
      end
      seed_we_i = ($urandom % 50) == 0;
      seed_sel_i = 3'($urandom);
      seed_i = ($urandom % 5 == 0) ? 25'h1FF_FFFF : 25'($urandom);
      tick;
    end
    sample_i = 1'b0; seed_we_i = 1'b0;
    repeat (4) tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
